led_pattern_controller: RTL

Sequencer that owns the 16 board LEDs and drives them from the 16 slide switches in one of four selectable display modes: pass-through, rotating pattern, free-running counter, blink. It sits between the top-level SW/LED pins and replaces the direct switch-to-LED wiring. Two push-button inputs step through modes and load switch values. All outputs are registered.

---
 rtl/led_pattern_controller.sv | 139 +++++++++++++
 1 files changed

// File: rtl/led_pattern_controller.sv
// LED sequencer: drives the board LEDs from the slide switches in one of four
// modes (pass-through, rotate, count, blink), stepped and loaded by two buttons.
module led_pattern_controller #(
   parameter int unsigned TICK_DIV = 50000000,
   parameter int unsigned WIDTH    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] SW,
   input  logic             btn_next,
   input  logic             btn_load,
   output logic [WIDTH-1:0] LED,
   output logic [1:0]       mode
);

   localparam int unsigned PW = $clog2(TICK_DIV);

   typedef enum logic [1:0] {
      MODE_PASS   = 2'd0,
      MODE_ROTATE = 2'd1,
      MODE_COUNT  = 2'd2,
      MODE_BLINK  = 2'd3
   } mode_e;

   mode_e            state_q, state_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic [WIDTH-1:0] pattern_q, pattern_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic             phase_q, phase_d;
   logic [WIDTH-1:0] led_q, led_d;

   logic [1:0]       next_sync_q, load_sync_q;
   logic             next_prev_q, load_prev_q;
   logic             next_arm_q, load_arm_q;
   logic [1:0]       sync_vld_q;

   logic             tick;
   logic             next_pulse;
   logic             load_pulse;
   logic [WIDTH-1:0] load_pat;

   // Arm flags keep a button held through reset from firing: they only set once
   // the synchronizer holds a real (post-reset) sample showing the button released.
   always_ff @(posedge clk) begin
      if (rst) begin
         next_sync_q <= 2'b00;
         load_sync_q <= 2'b00;
         next_prev_q <= 1'b0;
         load_prev_q <= 1'b0;
         next_arm_q  <= 1'b0;
         load_arm_q  <= 1'b0;
         sync_vld_q  <= 2'b00;
      end else begin
         next_sync_q <= {next_sync_q[0], btn_next};
         load_sync_q <= {load_sync_q[0], btn_load};
         next_prev_q <= next_sync_q[1];
         load_prev_q <= load_sync_q[1];
         sync_vld_q  <= {sync_vld_q[0], 1'b1};
         next_arm_q  <= next_arm_q | (sync_vld_q[1] & ~next_sync_q[1]);
         load_arm_q  <= load_arm_q | (sync_vld_q[1] & ~load_sync_q[1]);
      end
   end

   assign next_pulse = next_sync_q[1] & ~next_prev_q & next_arm_q;
   assign load_pulse = load_sync_q[1] & ~load_prev_q & load_arm_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= MODE_PASS;
         presc_q   <= '0;
         pattern_q <= WIDTH'(1);
         cnt_q     <= '0;
         phase_q   <= 1'b1;
         led_q     <= '0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         pattern_q <= pattern_d;
         cnt_q     <= cnt_d;
         phase_q   <= phase_d;
         led_q     <= led_d;
      end
   end

   assign tick     = (presc_q == PW'(TICK_DIV - 1));
   assign load_pat = (SW == '0) ? WIDTH'(1) : SW;

   // Priority: mode step, then load, then tick.
   always_comb begin
      state_d   = state_q;
      pattern_d = pattern_q;
      cnt_d     = cnt_q;
      phase_d   = phase_q;
      presc_d   = tick ? '0 : presc_q + PW'(1);
      led_d     = '0;

      case (state_q)
         MODE_PASS:   led_d = SW;
         MODE_ROTATE: led_d = pattern_q;
         MODE_COUNT:  led_d = cnt_q;
         MODE_BLINK:  led_d = phase_q ? SW : '0;
         default:     led_d = '0;
      endcase

      if (next_pulse) begin
         presc_d = '0;
         case (state_q)
            MODE_PASS: begin
               state_d   = MODE_ROTATE;
               pattern_d = load_pat;
            end
            MODE_ROTATE: begin
               state_d = MODE_COUNT;
               cnt_d   = '0;
            end
            MODE_COUNT: begin
               state_d = MODE_BLINK;
               phase_d = 1'b1;
            end
            default: state_d = MODE_PASS;
         endcase
      end else if (load_pulse && (state_q == MODE_ROTATE)) begin
         pattern_d = load_pat;
      end else if (load_pulse && (state_q == MODE_COUNT)) begin
         cnt_d = SW;
      end else if (tick) begin
         case (state_q)
            MODE_ROTATE: pattern_d = {pattern_q[WIDTH-2:0], pattern_q[WIDTH-1]};
            MODE_COUNT:  cnt_d     = cnt_q + WIDTH'(1);
            MODE_BLINK:  phase_d   = ~phase_q;
            default:     ;
         endcase
      end
   end

   assign LED  = led_q;
   assign mode = state_q;

endmodule
